invader_march_ctrl: RTL
=======================

# invader_march_ctrl

Sequencer for the invader formation. It owns the formation origin and decides, once per video frame, whether the grid steps sideways, drops and reverses, has landed, or has been cleared. March speed scales with the number of live invaders. It sits between the per-invader alive mask and the invader position generator and color mapper, and replaces free-running per-invader motion.

## Interface
- `COLS`, 10: invader columns; index i = row*COLS + col
- `ROWS`, 5: invader rows
- `PITCH_X` / `PITCH_Y`, 48 / 32: grid spacing in pixels
- `INV_W` / `INV_H`, 32 / 24: sprite size
- `X_MIN` / `X_MAX`, 8 / 631: horizontal playfield limits, inclusive
- `Y_LAND`, 440: formation landing line
- `START_X` / `START_Y`, 80 / 40: origin after Start
- `STEP_X` / `STEP_Y`, 4 / 16: sideways step and drop size
- `MIN_PERIOD`, 2: frames per step when one invader is alive
- `Clk` input 1: system clock; the only clock
- `Reset_n` input 1: asynchronous assert, active-low
- `vsync` input 1: raw VGA vsync, asynchronous to `Clk`
- `Start` input 1: one-cycle pulse that (re)launches a wave
- `Pause` input 1: level; freezes the frame counter and all motion
- `InvaderOn` input COLS*ROWS: alive mask, bit i = invader i
- `FormX`, `FormY` output 10: origin of invader (row 0, col 0)
- `Dir` output 1: 1 = moving right
- `StepPulse` output 1: one-cycle strobe for each sideways step or drop
- `AnimPhase` output 1: toggles on every StepPulse; selects the sprite frame
- `Landed` output 1: formation has reached `Y_LAND`
- `Cleared` output 1: all invaders are dead

## Operation
- **Frame tick:**
  - `vsync` passes through a 2-flop synchronizer, then a rising-edge detect.
  - This produces `tick`, one cycle high.
- **Counts and extents:** registered on every tick.
  - `alive`: 6-bit popcount of `InvaderOn`.
  - `colmin`, `colmax`: lowest and highest column with any live row.
  - `rowmax`: lowest-on-screen live row.
- **Period:** `MIN_PERIOD + (alive >> 2)` frames.
  - 50 alive gives 14.
  - 1 alive gives 2.
- **States:** IDLE, MARCH, LANDED, CLEARED. Reset and Start behave as follows:
  - Reset enters IDLE.
  - Start from any state enters MARCH.
  - Start loads `FormX`=`START_X`, `FormY`=`START_Y`, `Dir`=1, frame counter=0, `AnimPhase`=0.
- **MARCH:** on each tick with `Pause`=0, `fcnt` increments. When `fcnt` ≥ period−1 it clears to 0 and one move is evaluated:
  - **Right:** if `FormX + colmax*PITCH_X + INV_W - 1 + STEP_X > X_MAX`, drop. Otherwise `FormX += STEP_X`.
  - **Left:** if `FormX + colmin*PITCH_X < X_MIN + STEP_X`, drop. Otherwise `FormX -= STEP_X`.
  - **Drop:** `FormY += STEP_Y`, `Dir` inverts, `FormX` is unchanged.
  - Every move, sideways or drop, pulses `StepPulse` and toggles `AnimPhase`.
- **Exits from MARCH:**
  - After a move, if `FormY + rowmax*PITCH_Y + INV_H - 1 ≥ Y_LAND`, go to LANDED.
  - If `alive`=0 is seen on a tick, go to CLEARED. This takes priority over any move on that tick.
- **LANDED / CLEARED:** hold position, and hold `Landed` / `Cleared` at 1 until Start.
- **Arithmetic:** all extent arithmetic is unsigned 11-bit, so there is no 10-bit wrap. `FormX`/`FormY` are stored as 10 bits.

## Timing
- **Reset values:**
  - `FormX`=`START_X`, `FormY`=`START_Y`, `Dir`=1.
  - `StepPulse`, `AnimPhase`, `Landed`, `Cleared` = 0.
  - State is IDLE.
- **Tick latency:** `tick` fires 3 `Clk` edges after `vsync` rises.
- **Move latency:** `FormX`/`FormY`/`Dir`/`StepPulse` update 1 cycle after the evaluating tick. The extents used are the ones registered on the previous tick, which allows one frame of staleness.
- **Start and tick together:** Start wins and the tick is discarded.
- **Pause during MARCH:** ticks are ignored and `fcnt` holds.
- **Reset mid-march:** all outputs return to reset values asynchronously.
- **`InvaderOn` changes:** may change on any cycle. Only the tick-sampled copy is used.

## Structure
- Package `invader_pkg`:
  - State enum `march_state_t`.
  - Geometry constants shared with the color mapper: `COLS`, `ROWS`, `PITCH_X`/`PITCH_Y`, `INV_W`/`INV_H`.
- Sub-module `alive_extent`: combinational popcount plus column/row min/max from the mask. It is reused by the shot block.

## Test plan
- **Reset then Start, 50 alive:** first `StepPulse` 14 ticks after Start, `FormX`=84, `AnimPhase`=1.
- **Right edge, columns 0–9 alive:** the next move is a drop, not a step: `FormY`=56, `Dir`=0, `FormX` unchanged.
- **Only column 0 alive, moving right:** the formation travels past the full-grid edge before dropping. This checks that the extent uses `colmax`.
- **Clear mask to 1 invader:** period becomes 2 ticks, and `StepPulse` is spaced 2 frames apart.
- **Advance `FormY` until row 4 bottom ≥ 440:** `Landed`=1 and held, with no further `StepPulse`.
- **Mask to all zeros:** `Cleared`=1 on the next tick. Then assert Start together with a vsync edge: MARCH resumes, outputs are at start values, and there is no step.

Source files
------------

// File: rtl/invader_pkg.sv
// Shared formation geometry, derived widths and the march sequencer state type.
package invader_pkg;

    localparam int COLS    = 10;
    localparam int ROWS    = 5;
    localparam int PITCH_X = 48;
    localparam int PITCH_Y = 32;
    localparam int INV_W   = 32;
    localparam int INV_H   = 24;

    localparam int NINV    = COLS * ROWS;
    localparam int ALIVE_W = 6;
    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = $clog2(ROWS);
    // Extent sums are carried one bit wider than the 10-bit origin so they never wrap
    localparam int EXT_W   = 11;

    typedef enum logic [1:0] {
        IDLE,
        MARCH,
        LANDED,
        CLEARED
    } march_state_t;

endpackage

// File: rtl/alive_extent.sv
// Live-invader count and occupied column/row extents of an alive mask.
module alive_extent
    import invader_pkg::*;
(
    input  logic [NINV-1:0]    mask,
    output logic [ALIVE_W-1:0] alive,
    output logic [COL_W-1:0]   colmin,
    output logic [COL_W-1:0]   colmax,
    output logic [ROW_W-1:0]   rowmax
);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    // Popcount plus per-column / per-row occupancy, then priority scans for the extents.
    // An empty mask reports all extents as 0.
    always_comb begin
        alive   = '0;
        col_any = '0;
        row_any = '0;
        colmin  = '0;
        colmax  = '0;
        rowmax  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                alive      = alive + ALIVE_W'(mask[r*COLS + c]);
                col_any[c] = col_any[c] | mask[r*COLS + c];
                row_any[r] = row_any[r] | mask[r*COLS + c];
            end
        end
        for (int c = COLS - 1; c >= 0; c--)
            if (col_any[c]) colmin = COL_W'(c);
        for (int c = 0; c < COLS; c++)
            if (col_any[c]) colmax = COL_W'(c);
        for (int r = 0; r < ROWS; r++)
            if (row_any[r]) rowmax = ROW_W'(r);
    end

endmodule

// File: rtl/invader_march_ctrl.sv
// Per-frame formation sequencer: sideways steps, edge drops, landing and clear detection.
module invader_march_ctrl
    import invader_pkg::*;
#(
    parameter int X_MIN      = 8,
    parameter int X_MAX      = 631,
    parameter int Y_LAND     = 440,
    parameter int START_X    = 80,
    parameter int START_Y    = 40,
    parameter int STEP_X     = 4,
    parameter int STEP_Y     = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            vsync,
    input  logic            Start,
    input  logic            Pause,
    input  logic [NINV-1:0] InvaderOn,
    output logic [9:0]      FormX,
    output logic [9:0]      FormY,
    output logic            Dir,
    output logic            StepPulse,
    output logic            AnimPhase,
    output logic            Landed,
    output logic            Cleared
);

    localparam int FCNT_W = 6;

    march_state_t        state_q, state_d;
    logic                vs_meta, vs_sync, vs_prev, tick;
    logic [ALIVE_W-1:0]  alive_c, alive_q;
    logic [COL_W-1:0]    colmin_c, colmax_c, colmin_q, colmax_q;
    logic [ROW_W-1:0]    rowmax_c, rowmax_q;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d, period_m1;
    logic [9:0]          fx_d, fy_d;
    logic                dir_d, phase_d, step_d;
    logic [EXT_W-1:0]    right_edge, left_edge, bottom;
    logic                hit_right, hit_left;

    alive_extent u_extent (
        .mask   (InvaderOn),
        .alive  (alive_c),
        .colmin (colmin_c),
        .colmax (colmax_c),
        .rowmax (rowmax_c)
    );

    // vsync crosses into Clk through two flops; the third flop gives the rising-edge tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign tick = vs_sync & ~vs_prev;

    // Frame snapshot of the mask; moves use the previous snapshot (one frame stale)
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            alive_q  <= '0;
            colmin_q <= '0;
            colmax_q <= '0;
            rowmax_q <= '0;
        end else if (tick) begin
            alive_q  <= alive_c;
            colmin_q <= colmin_c;
            colmax_q <= colmax_c;
            rowmax_q <= rowmax_c;
        end
    end

    assign period_m1  = FCNT_W'(MIN_PERIOD - 1) + FCNT_W'(alive_q >> 2);
    assign right_edge = EXT_W'(FormX) + EXT_W'(colmax_q) * EXT_W'(PITCH_X) + EXT_W'(INV_W - 1 + STEP_X);
    assign left_edge  = EXT_W'(FormX) + EXT_W'(colmin_q) * EXT_W'(PITCH_X);
    assign hit_right  = right_edge > EXT_W'(X_MAX);
    assign hit_left   = left_edge < EXT_W'(X_MIN + STEP_X);

    // Next state and next formation position; Start overrides any tick in the same cycle
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        fx_d    = FormX;
        fy_d    = FormY;
        dir_d   = Dir;
        phase_d = AnimPhase;
        step_d  = 1'b0;
        bottom  = '0;
        if (Start) begin
            state_d = MARCH;
            fcnt_d  = '0;
            fx_d    = 10'(START_X);
            fy_d    = 10'(START_Y);
            dir_d   = 1'b1;
            phase_d = 1'b0;
        end else if (tick && !Pause && state_q == MARCH) begin
            if (alive_c == '0) begin
                state_d = CLEARED;
            end else if (fcnt_q >= period_m1) begin
                fcnt_d  = '0;
                step_d  = 1'b1;
                phase_d = ~AnimPhase;
                if (Dir ? hit_right : hit_left) begin
                    fy_d  = FormY + 10'(STEP_Y);
                    dir_d = ~Dir;
                end else begin
                    fx_d = Dir ? FormX + 10'(STEP_X) : FormX - 10'(STEP_X);
                end
                bottom = EXT_W'(fy_d) + EXT_W'(rowmax_q) * EXT_W'(PITCH_Y) + EXT_W'(INV_H - 1);
                if (bottom >= EXT_W'(Y_LAND)) state_d = LANDED;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Sequencer state, frame counter and formation outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            fcnt_q    <= '0;
            FormX     <= 10'(START_X);
            FormY     <= 10'(START_Y);
            Dir       <= 1'b1;
            AnimPhase <= 1'b0;
            StepPulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            FormX     <= fx_d;
            FormY     <= fy_d;
            Dir       <= dir_d;
            AnimPhase <= phase_d;
            StepPulse <= step_d;
        end
    end

    assign Landed  = (state_q == LANDED);
    assign Cleared = (state_q == CLEARED);

endmodule
